// File: rtl/accelerator_tensor_fixed_transmitter.sv
// accelerator_tensor_fixed_transmitter
// Streams an I x J x K fixed-point tensor out of a synchronous-read buffer,
// i-major then j then k, framed with the I/J/K enable protocol.
// Build option: define ACCELERATOR_TENSOR_FIXED_TRANSMITTER_BASE_ADDR_EN to add
// BASE_ADDR_IN, an offset latched on START and added to every read address.
module accelerator_tensor_fixed_transmitter #(
    parameter int DATA_SIZE    = 64,
    parameter int CONTROL_SIZE = 64
) (
    input  logic                    CLK,
    input  logic                    RST,
    input  logic                    START,
    output logic                    READY,
    input  logic [DATA_SIZE-1:0]    SIZE_I_IN,
    input  logic [DATA_SIZE-1:0]    SIZE_J_IN,
    input  logic [DATA_SIZE-1:0]    SIZE_K_IN,
`ifdef ACCELERATOR_TENSOR_FIXED_TRANSMITTER_BASE_ADDR_EN
    input  logic [CONTROL_SIZE-1:0] BASE_ADDR_IN,
`endif
    output logic                    RD_ENABLE,
    output logic [CONTROL_SIZE-1:0] ADDR_OUT,
    input  logic [DATA_SIZE-1:0]    DATA_IN,
    output logic [DATA_SIZE-1:0]    DATA_OUT,
    output logic                    DATA_OUT_I_ENABLE,
    output logic                    DATA_OUT_J_ENABLE,
    output logic                    DATA_OUT_K_ENABLE
);

    localparam logic [1:0] STARTER_STATE = 2'd0;
    localparam logic [1:0] READ_STATE    = 2'd1;
    localparam logic [1:0] DRAIN_STATE   = 2'd2;
    localparam logic [1:0] ENDER_STATE   = 2'd3;

    localparam logic [CONTROL_SIZE-1:0] ONE = CONTROL_SIZE'(1);

    // Control state: FSM, latched sizes, nested counters, linear address
    logic [1:0]              state_q, state_d;
    logic [CONTROL_SIZE-1:0] size_i_q, size_i_d;
    logic [CONTROL_SIZE-1:0] size_j_q, size_j_d;
    logic [CONTROL_SIZE-1:0] size_k_q, size_k_d;
    logic [CONTROL_SIZE-1:0] cnt_i_q, cnt_i_d;
    logic [CONTROL_SIZE-1:0] cnt_j_q, cnt_j_d;
    logic [CONTROL_SIZE-1:0] cnt_k_q, cnt_k_d;
    logic [CONTROL_SIZE-1:0] addr_q, addr_d;
    logic                    ready_q, ready_d;

    // Stage 1: read strobe plus the tags of the element being read
    logic rd_q, rd_d;
    logic tag_i1_q, tag_i1_d;
    logic tag_j1_q, tag_j1_d;

    // Stage 2: DATA_IN is valid for the read issued one cycle earlier
    logic v2_q, tag_i2_q, tag_j2_q;

    // Output stage
    logic [DATA_SIZE-1:0] data_q;
    logic                 en_i_q, en_j_q, en_k_q;

    logic [CONTROL_SIZE-1:0] base_addr;
    logic                    k_last, j_last, i_last, any_zero;

`ifdef ACCELERATOR_TENSOR_FIXED_TRANSMITTER_BASE_ADDR_EN
    assign base_addr = BASE_ADDR_IN;
`else
    assign base_addr = '0;
`endif

    assign k_last   = (cnt_k_q == size_k_q - ONE);
    assign j_last   = (cnt_j_q == size_j_q - ONE);
    assign i_last   = (cnt_i_q == size_i_q - ONE);
    assign any_zero = (SIZE_I_IN[CONTROL_SIZE-1:0] == '0) ||
                      (SIZE_J_IN[CONTROL_SIZE-1:0] == '0) ||
                      (SIZE_K_IN[CONTROL_SIZE-1:0] == '0);

    // Next-state logic: FSM sequencing, counter walk and read issue
    always_comb begin
        // NOTE: every target gets a default first so no path leaves it unassigned, which would infer a latch.
        state_d  = state_q;
        size_i_d = size_i_q;
        size_j_d = size_j_q;
        size_k_d = size_k_q;
        cnt_i_d  = cnt_i_q;
        cnt_j_d  = cnt_j_q;
        cnt_k_d  = cnt_k_q;
        addr_d   = addr_q;
        rd_d     = 1'b0;
        tag_i1_d = 1'b0;
        tag_j1_d = 1'b0;
        ready_d  = 1'b0;
        case (state_q)
            STARTER_STATE: begin
                if (START) begin
                    size_i_d = SIZE_I_IN[CONTROL_SIZE-1:0];
                    size_j_d = SIZE_J_IN[CONTROL_SIZE-1:0];
                    size_k_d = SIZE_K_IN[CONTROL_SIZE-1:0];
                    cnt_i_d  = '0;
                    cnt_j_d  = '0;
                    cnt_k_d  = '0;
                    addr_d   = base_addr;
                    if (any_zero) begin
                        state_d = ENDER_STATE;
                        ready_d = 1'b1;
                    end else begin
                        // Element 0 is issued in the very next cycle
                        state_d  = READ_STATE;
                        rd_d     = 1'b1;
                        tag_i1_d = 1'b1;
                        tag_j1_d = 1'b1;
                    end
                end
            end
            READ_STATE: begin
                if (k_last && j_last && i_last) begin
                    state_d = DRAIN_STATE;
                end else begin
                    rd_d   = 1'b1;
                    addr_d = addr_q + ONE;
                    if (k_last) begin
                        cnt_k_d  = '0;
                        tag_j1_d = 1'b1;
                        if (j_last) begin
                            cnt_j_d  = '0;
                            cnt_i_d  = cnt_i_q + ONE;
                            tag_i1_d = 1'b1;
                        end else begin
                            cnt_j_d = cnt_j_q + ONE;
                        end
                    end else begin
                        cnt_k_d = cnt_k_q + ONE;
                    end
                end
            end
            DRAIN_STATE: begin
                // Both pipeline stages empty: the last element is on DATA_OUT now
                if (!rd_q && !v2_q) begin
                    state_d = ENDER_STATE;
                    ready_d = 1'b1;
                end
            end
            default: begin
                state_d = STARTER_STATE;
            end
        endcase
    end

    // Control registers
    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            state_q  <= STARTER_STATE;
            size_i_q <= '0;
            size_j_q <= '0;
            size_k_q <= '0;
            cnt_i_q  <= '0;
            cnt_j_q  <= '0;
            cnt_k_q  <= '0;
            addr_q   <= '0;
            rd_q     <= 1'b0;
            tag_i1_q <= 1'b0;
            tag_j1_q <= 1'b0;
            ready_q  <= 1'b0;
        end else begin
            // NOTE: non-blocking assignments so every register samples pre-edge values.
            state_q  <= state_d;
            size_i_q <= size_i_d;
            size_j_q <= size_j_d;
            size_k_q <= size_k_d;
            cnt_i_q  <= cnt_i_d;
            cnt_j_q  <= cnt_j_d;
            cnt_k_q  <= cnt_k_d;
            addr_q   <= addr_d;
            rd_q     <= rd_d;
            tag_i1_q <= tag_i1_d;
            tag_j1_q <= tag_j1_d;
            ready_q  <= ready_d;
        end
    end

    // Tag pipeline and output register; DATA_OUT holds between elements
    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            v2_q     <= 1'b0;
            tag_i2_q <= 1'b0;
            tag_j2_q <= 1'b0;
            data_q   <= '0;
            en_i_q   <= 1'b0;
            en_j_q   <= 1'b0;
            en_k_q   <= 1'b0;
        end else begin
            v2_q     <= rd_q;
            tag_i2_q <= tag_i1_q;
            tag_j2_q <= tag_j1_q;
            en_k_q   <= v2_q;
            en_j_q   <= v2_q & tag_j2_q;
            en_i_q   <= v2_q & tag_i2_q;
            if (v2_q) begin
                data_q <= DATA_IN;
            end
        end
    end

    assign READY             = ready_q;
    assign RD_ENABLE         = rd_q;
    assign ADDR_OUT          = addr_q;
    assign DATA_OUT          = data_q;
    assign DATA_OUT_I_ENABLE = en_i_q;
    assign DATA_OUT_J_ENABLE = en_j_q;
    assign DATA_OUT_K_ENABLE = en_k_q;

endmodule

// File: tb/tb_accelerator_tensor_fixed_transmitter.sv
// Testbench for accelerator_tensor_fixed_transmitter: a table of transfer shapes
// plus hand-written sequences (zero size with immediate restart, START re-pulse,
// START held high, reset mid-transfer). A scoreboard holds expected reads,
// elements and READY pulses with the cycle each must appear in.
module tb_accelerator_tensor_fixed_transmitter;

    localparam int DW = 64;
    localparam int CW = 64;

`ifdef ACCELERATOR_TENSOR_FIXED_TRANSMITTER_BASE_ADDR_EN
    localparam bit BASE_EN = 1'b1;
`else
    localparam bit BASE_EN = 1'b0;
`endif

    logic          clk = 1'b0;
    logic          rst_n;
    logic          start;
    logic          ready;
    logic [DW-1:0] size_i, size_j, size_k;
    logic [CW-1:0] base_addr;
    logic          rd_enable;
    logic [CW-1:0] addr_out;
    logic [DW-1:0] data_in;
    logic [DW-1:0] data_out;
    logic          en_i, en_j, en_k;

    accelerator_tensor_fixed_transmitter #(.DATA_SIZE(DW), .CONTROL_SIZE(CW)) dut (
        .CLK               (clk),
        .RST               (rst_n),
        .START             (start),
        .READY             (ready),
        .SIZE_I_IN         (size_i),
        .SIZE_J_IN         (size_j),
        .SIZE_K_IN         (size_k),
`ifdef ACCELERATOR_TENSOR_FIXED_TRANSMITTER_BASE_ADDR_EN
        .BASE_ADDR_IN      (base_addr),
`endif
        .RD_ENABLE         (rd_enable),
        .ADDR_OUT          (addr_out),
        .DATA_IN           (data_in),
        .DATA_OUT          (data_out),
        .DATA_OUT_I_ENABLE (en_i),
        .DATA_OUT_J_ENABLE (en_j),
        .DATA_OUT_K_ENABLE (en_k)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // Buffer model: mem[a] = a + data_off, one-cycle synchronous read
    logic [DW-1:0] data_off = '0;
    initial data_in = '0;
    always @(posedge clk) if (rd_enable) data_in <= addr_out + data_off;

    typedef struct { int cyc; logic [CW-1:0] addr; } rd_exp_t;
    typedef struct { int cyc; logic [DW-1:0] data; logic ie; logic je; } out_exp_t;
    typedef struct {
        int si; int sj; int sk;
        logic [CW-1:0] base; logic [DW-1:0] off;
        int exp_n; int exp_i; int exp_j;
    } vec_t;

    rd_exp_t  exp_rd[$];
    out_exp_t exp_out[$];
    int       exp_ready[$];

    int n_cmp = 0;
    int n_fail = 0;
    int elem_cnt, i_cnt, j_cnt;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Expected reads/elements/READY for a transfer whose START is sampled in cycle s
    task automatic push_expect(input int si, input int sj, input int sk,
                               input logic [CW-1:0] base, input int s);
        int n;
        logic [CW-1:0] b;
        b = BASE_EN ? base : '0;
        n = 0;
        if (si == 0 || sj == 0 || sk == 0) begin
            exp_ready.push_back(s + 1);
            return;
        end
        for (int i = 0; i < si; i++)
            for (int j = 0; j < sj; j++)
                for (int k = 0; k < sk; k++) begin
                    exp_rd.push_back('{cyc: s + 1 + n, addr: b + CW'(n)});
                    exp_out.push_back('{cyc: s + 3 + n, data: b + CW'(n) + data_off,
                                        ie: (j == 0 && k == 0), je: (k == 0)});
                    n++;
                end
        exp_ready.push_back(s + 3 + n);
    endtask

    // Called at a falling edge: START is high for exactly this cycle
    task automatic launch(input int si, input int sj, input int sk, input logic [CW-1:0] base);
        size_i    = DW'(si);
        size_j    = DW'(sj);
        size_k    = DW'(sk);
        base_addr = base;
        start     = 1'b1;
        push_expect(si, sj, sk, base, cyc);
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic wait_done();
        for (int t = 0; t < 400 && (exp_rd.size() + exp_out.size() + exp_ready.size()) > 0; t++)
            @(negedge clk);
        repeat (3) @(negedge clk);
        check("pending_reads", 64'(exp_rd.size()), 64'd0);
        check("pending_elems", 64'(exp_out.size()), 64'd0);
        check("pending_ready", 64'(exp_ready.size()), 64'd0);
    endtask

    task automatic check_counts(input string tag, input int n, input int ni, input int nj);
        check({tag, "_elems"}, 64'(elem_cnt), 64'(n));
        check({tag, "_i_en"},  64'(i_cnt),    64'(ni));
        check({tag, "_j_en"},  64'(j_cnt),    64'(nj));
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_rd"},    64'(rd_enable), 64'd0);
        check({tag, "_addr"},  addr_out,       64'd0);
        check({tag, "_data"},  data_out,       64'd0);
        check({tag, "_en"},    64'({en_i, en_j, en_k}), 64'd0);
        check({tag, "_ready"}, 64'(ready),     64'd0);
    endtask

    // Monitor: sample outputs mid-cycle and score them against the queues
    always @(negedge clk) begin
        rd_exp_t  er;
        out_exp_t eo;
        int       ec;
        if (rst_n) begin
            if (rd_enable) begin
                check("rd_pending", 64'(exp_rd.size() > 0), 64'd1);
                if (exp_rd.size() > 0) begin
                    er = exp_rd.pop_front();
                    check("rd_cycle", 64'(cyc), 64'(er.cyc));
                    check("rd_addr", addr_out, er.addr);
                end
            end
            if (en_k) begin
                elem_cnt++;
                if (en_i) i_cnt++;
                if (en_j) j_cnt++;
                check("elem_pending", 64'(exp_out.size() > 0), 64'd1);
                if (exp_out.size() > 0) begin
                    eo = exp_out.pop_front();
                    check("elem_cycle", 64'(cyc), 64'(eo.cyc));
                    check("elem_data", data_out, eo.data);
                    check("elem_ij", 64'({en_i, en_j}), 64'({eo.ie, eo.je}));
                end
            end else begin
                check("orphan_ij", 64'({en_i, en_j}), 64'd0);
            end
            if (ready) begin
                check("ready_pending", 64'(exp_ready.size() > 0), 64'd1);
                if (exp_ready.size() > 0) begin
                    ec = exp_ready.pop_front();
                    check("ready_cycle", 64'(cyc), 64'(ec));
                end
            end
        end
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    vec_t vecs[8];

    initial begin
        int s;
        vecs[0] = '{si: 2, sj: 2, sk: 2, base: 64'h0,  off: 64'd100,  exp_n: 8, exp_i: 2, exp_j: 4};
        vecs[1] = '{si: 1, sj: 1, sk: 1, base: 64'h0,  off: 64'h5A,   exp_n: 1, exp_i: 1, exp_j: 1};
        vecs[2] = '{si: 1, sj: 2, sk: 2, base: 64'h10, off: 64'd0,    exp_n: 4, exp_i: 1, exp_j: 2};
        vecs[3] = '{si: 2, sj: 3, sk: 1, base: 64'h0,  off: 64'd7,    exp_n: 6, exp_i: 2, exp_j: 6};
        vecs[4] = '{si: 1, sj: 1, sk: 5, base: 64'h20, off: 64'd1000, exp_n: 5, exp_i: 1, exp_j: 1};
        vecs[5] = '{si: 4, sj: 1, sk: 1, base: 64'h0,  off: 64'd3,    exp_n: 4, exp_i: 4, exp_j: 4};
        vecs[6] = '{si: 0, sj: 3, sk: 3, base: 64'h0,  off: 64'd0,    exp_n: 0, exp_i: 0, exp_j: 0};
        vecs[7] = '{si: 2, sj: 2, sk: 0, base: 64'h0,  off: 64'd0,    exp_n: 0, exp_i: 0, exp_j: 0};

        rst_n = 1'b0; start = 1'b0;
        size_i = '0; size_j = '0; size_k = '0; base_addr = '0;
        repeat (3) @(negedge clk);
        check_all_zero("reset_state");
        rst_n = 1'b1;
        repeat (2) @(negedge clk);

        // Table-driven transfers
        for (int v = 0; v < 8; v++) begin
            data_off = vecs[v].off;
            elem_cnt = 0; i_cnt = 0; j_cnt = 0;
            launch(vecs[v].si, vecs[v].sj, vecs[v].sk, vecs[v].base);
            wait_done();
            check_counts($sformatf("vec%0d", v), vecs[v].exp_n, vecs[v].exp_i, vecs[v].exp_j);
        end

        // Zero J: READY in s+1, then a START in s+2 is accepted
        data_off = 64'h5A;
        elem_cnt = 0; i_cnt = 0; j_cnt = 0;
        launch(2, 0, 2, '0);
        @(negedge clk);
        launch(1, 1, 1, '0);
        wait_done();
        check_counts("zero_restart", 1, 1, 1);

        // 3x1x4 with START re-pulsed (and sizes changed) during READ_STATE
        data_off = 64'd100;
        elem_cnt = 0; i_cnt = 0; j_cnt = 0;
        launch(3, 1, 4, '0);
        repeat (2) @(negedge clk);
        size_i = 64'd1; size_j = 64'd1; size_k = 64'd1;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        wait_done();
        check_counts("repulse", 12, 3, 3);

        // START held high: the second transfer starts in the first STARTER cycle (s+4+N)
        data_off = 64'd50;
        elem_cnt = 0; i_cnt = 0; j_cnt = 0;
        size_i = 64'd1; size_j = 64'd1; size_k = 64'd2; base_addr = '0;
        s = cyc;
        start = 1'b1;
        push_expect(1, 1, 2, '0, s);
        push_expect(1, 1, 2, '0, s + 6);
        repeat (7) @(negedge clk);
        start = 1'b0;
        wait_done();
        check_counts("held_start", 4, 2, 2);

        // Reset asserted in cycle s+5 of a 2x2x2 transfer
        data_off = 64'd100;
        elem_cnt = 0; i_cnt = 0; j_cnt = 0;
        launch(2, 2, 2, '0);
        repeat (3) @(negedge clk);
        @(posedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        check_all_zero("async_reset");
        exp_rd.delete(); exp_out.delete(); exp_ready.delete();
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        repeat (12) @(negedge clk);
        elem_cnt = 0; i_cnt = 0; j_cnt = 0;
        launch(2, 2, 2, '0);
        wait_done();
        check_counts("after_reset", 8, 2, 4);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule

// File: doc/accelerator_tensor_fixed_transmitter.md
# accelerator_tensor_fixed_transmitter

Streams a fixed-point tensor out of a synchronous-read buffer as a framed element sequence, i-major then j then k. On each element it asserts DATA_OUT_K_ENABLE, plus DATA_OUT_J_ENABLE at row starts and DATA_OUT_I_ENABLE at slice starts. It is the producer side of the I/J/K enable protocol consumed by the tensor arithmetic units (e.g. feeding DATA_A_IN/DATA_B_IN of the tensor multiplier), and it walks the tensor with nested counters.

## Interface
Parameters:
- DATA_SIZE, 64, element and size-input width
- CONTROL_SIZE, 64, counter and address width

Ports:
- CLK  input  1  clock, all state on rising edge
- RST  input  1  reset, asynchronous, active-low
- START  input  1  begin transfer; sampled only in STARTER_STATE
- READY  output  1  one-cycle pulse when transfer complete
- SIZE_I_IN  input  DATA_SIZE  number of i slices; low CONTROL_SIZE bits used
- SIZE_J_IN  input  DATA_SIZE  rows per slice
- SIZE_K_IN  input  DATA_SIZE  elements per row
- RD_ENABLE  output  1  buffer read strobe
- ADDR_OUT  output  CONTROL_SIZE  buffer read address
- DATA_IN  input  DATA_SIZE  buffer read data, valid the cycle after RD_ENABLE
- DATA_OUT  output  DATA_SIZE  streamed element
- DATA_OUT_I_ENABLE  output  1  first element of an i slice
- DATA_OUT_J_ENABLE  output  1  first element of a j row
- DATA_OUT_K_ENABLE  output  1  element valid

## Operation
- Reset (RST=0, any time, including mid-transfer):
  - All outputs 0.
  - FSM to STARTER_STATE.
  - Counters cleared; in-flight reads discarded.
  - No READY pulse.
- FSM states: STARTER_STATE, READ_STATE, DRAIN_STATE, ENDER_STATE.
- STARTER_STATE:
  - On START=1, latch the three sizes and clear i/j/k counters and the linear address.
  - If any size is 0: go to ENDER_STATE. No read and no enable is issued.
  - Otherwise go to READ_STATE.
- READ_STATE:
  - Each cycle drives RD_ENABLE=1 and ADDR_OUT=n, where n = i·J·K + j·K + k, kept as an incrementing linear counter (no multiplier).
  - Counters advance k, then j on k wrap, then i on j wrap.
  - After issuing the last element (i=I-1, j=J-1, k=K-1), go to DRAIN_STATE.
- Tag pipeline:
  - Each issued read carries tags {first_i = (j==0 && k==0), first_j = (k==0)}.
  - The tags travel two stages alongside the read.
  - In the cycle DATA_IN is valid, the block registers DATA_IN into DATA_OUT and asserts the enables: K always, J if first_j, I if first_i.
- DRAIN_STATE: waits for the last element to be emitted, then goes to ENDER_STATE.
- ENDER_STATE: drives READY=1 for one cycle, then returns to STARTER_STATE.
- Outputs outside valid cycles: DATA_OUT holds its last value; the three enables are 0.
- START is ignored in READ_STATE, DRAIN_STATE and ENDER_STATE.
- Width rules:
  - Address and counters wrap modulo 2^CONTROL_SIZE.
  - The element count I·J·K must fit in CONTROL_SIZE bits; larger products are out of contract.
- No backpressure: one element per cycle, contiguous.

## Timing
- All outputs are registered.
- START high in STARTER_STATE at cycle s (non-zero sizes, N = I·J·K):
  - RD_ENABLE=1, ADDR_OUT=n in cycle s+1+n, for n = 0..N-1.
  - DATA_IN for address n is valid in s+2+n.
  - DATA_OUT with its enables is valid in s+3+n.
  - READY=1 in cycle s+3+N; STARTER_STATE is re-entered in s+4+N.
- Zero size: READY=1 in cycle s+1; STARTER_STATE again in s+2.
- A START held high continuously begins a new transfer in the first STARTER_STATE cycle.

## Configuration
- ACCELERATOR_TENSOR_FIXED_TRANSMITTER_BASE_ADDR_EN:
  - Defined: adds input BASE_ADDR_IN (CONTROL_SIZE), latched on accepted START. ADDR_OUT = BASE_ADDR_IN + n, modulo 2^CONTROL_SIZE.
  - Undefined: no BASE_ADDR_IN port; ADDR_OUT = n, starting at 0.
  - Timing is identical in both builds.

## Test plan
- 2×2×2 transfer, buffer mem[a] = a+100, START at s:
  - ADDR_OUT 0..7 in s+1..s+8.
  - DATA_OUT 100..107 in s+3..s+10.
  - K_ENABLE on all 8 elements.
  - J_ENABLE on elements 0, 2, 4, 6.
  - I_ENABLE on elements 0, 4.
  - READY pulse in s+11.
- 1×1×1 transfer, mem[0] = 0x5A:
  - Single element 0x5A in s+3 with I, J, K enables all 1.
  - READY in s+4.
- SIZE_J_IN = 0:
  - No RD_ENABLE and no enables.
  - READY in s+1; the next START in s+2 is accepted.
- Sizes 3×1×4, with START re-pulsed during READ_STATE:
  - The re-pulse is ignored.
  - 12 contiguous elements; J_ENABLE on every 4th element; I_ENABLE on elements 0, 4, 8.
  - Exactly one READY.
- RST low asserted at s+5 of a 2×2×2 transfer:
  - All outputs 0 immediately, asynchronously.
  - No READY; after release, a new START runs a clean, complete transfer.
- With the macro defined, BASE_ADDR_IN = 0x10 on a 1×2×2 transfer:
  - ADDR_OUT 0x10..0x13.
  - Enable pattern identical to the no-macro build.
